sprite_addr_cal: RTL and testbench



---
 rtl/sprite_addr_cal.sv | 91 +++++++++
 tb/tb_sprite_addr_cal.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sprite_addr_cal.sv
// Per-pixel sprite ROM address generator with a one-cycle registered inside test and linear address.
// Optional horizontal mirroring is enabled by defining ADDR_CAL_HFLIP_EN.
module sprite_addr_cal #(
    parameter int ADDR_W  = 16,
    parameter int COORD_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [79:0]       pattern_info,
    input  logic [31:0]       sprite_info,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    output logic [ADDR_W-1:0] addr_output,
    output logic              valid
);

    localparam int PAD = ADDR_W - COORD_W;

    logic [ADDR_W-1:0]  pat_height;
    logic [ADDR_W-1:0]  pat_width;
    logic [ADDR_W-1:0]  pat_base;
    logic [COORD_W-1:0] spr_x;
    logic [COORD_W-1:0] spr_y;
    logic               spr_hflip;

    logic               h_ge_p0;
    logic               v_ge_p0;
    logic [COORD_W-1:0] col_p0;
    logic [COORD_W-1:0] row_p0;
    logic [ADDR_W-1:0]  col_ext_p0;
    logic [ADDR_W-1:0]  row_ext_p0;
    logic [ADDR_W-1:0]  col_eff_p0;
    logic               inside_p0;
    logic [ADDR_W-1:0]  addr_p0;

    assign pat_height = pattern_info[0 +: ADDR_W];
    assign pat_width  = pattern_info[16 +: ADDR_W];
    assign pat_base   = pattern_info[32 +: ADDR_W];
    assign spr_y      = sprite_info[0 +: COORD_W];
    assign spr_x      = sprite_info[10 +: COORD_W];

`ifdef ADDR_CAL_HFLIP_EN
    assign spr_hflip = sprite_info[31];
    logic unused_bits;
    assign unused_bits = ^{pattern_info[79:48], sprite_info[30:20]};
`else
    assign spr_hflip = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{pattern_info[79:48], sprite_info[31:20]};
`endif

    // Linear address; product and sum deliberately wrap modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] rom_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] row,
        input logic [ADDR_W-1:0] width,
        input logic [ADDR_W-1:0] col
    );
        logic [ADDR_W-1:0] prod;
        prod = row * width;
        return base + prod + col;
    endfunction

    // p0: inside test and address formation from the current inputs
    always_comb begin
        h_ge_p0    = hcount >= spr_x;
        v_ge_p0    = vcount >= spr_y;
        col_p0     = hcount - spr_x;
        row_p0     = vcount - spr_y;
        col_ext_p0 = {{PAD{1'b0}}, col_p0};
        row_ext_p0 = {{PAD{1'b0}}, row_p0};
        // The >= terms gate the differences, so a sprite hanging off the right edge never wraps.
        inside_p0  = h_ge_p0 && v_ge_p0 && (col_ext_p0 < pat_width) && (row_ext_p0 < pat_height);
        col_eff_p0 = spr_hflip ? (pat_width - {{(ADDR_W-1){1'b0}}, 1'b1} - col_ext_p0) : col_ext_p0;
        addr_p0    = '0;
        if (inside_p0)
            addr_p0 = rom_addr(pat_base, row_ext_p0, pat_width, col_eff_p0);
    end

    // p1: registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            valid       <= 1'b0;
            addr_output <= '0;
        end else begin
            valid       <= inside_p0;
            addr_output <= addr_p0;
        end
    end

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed-vector bench for sprite_addr_cal; expected values are hand-computed from the sprite geometry.
module tb_sprite_addr_cal;

    logic        clk;
    logic        reset;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    int total;
    int bad;

    sprite_addr_cal #(.ADDR_W(16), .COORD_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_sprite(input logic [15:0] base, input logic [15:0] w, input logic [15:0] h,
                              input logic [9:0] x, input logic [9:0] y, input logic hflip);
        // Reserved fields are filled with junk; they must not matter.
        pattern_info = {32'hDEAD_BEEF, base, w, h};
        sprite_info  = {hflip, 11'h5A5, x, y};
    endtask

    // Drive a pixel, let one edge capture it, then sample the outputs off the edge.
    task automatic pixel(input string tag, input logic [9:0] hc, input logic [9:0] vc,
                         input logic exp_v, input logic [15:0] exp_a);
        hcount = hc;
        vcount = vc;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, exp_v});
        check({tag, ".addr"}, {16'b0, addr_output}, {16'b0, exp_a});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_sprite(16'd0, 16'd64, 16'd64, 10'd100, 10'd50, 1'b0);
        hcount = 10'd100;
        vcount = 10'd50;
        @(posedge clk);
        #1;
        check("reset.valid", {31'b0, valid}, 32'd0);
        check("reset.addr", {16'b0, addr_output}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold.valid", {31'b0, valid}, 32'd0);
        reset = 1'b0;

        // Basic placement: x=100 y=50 64x64 base 0
        pixel("tl", 10'd100, 10'd50, 1'b1, 16'd0);
        pixel("br", 10'd163, 10'd113, 1'b1, 16'd4095);
        pixel("mid", 10'd110, 10'd52, 1'b1, 16'd138);
        set_sprite(16'h0100, 16'd64, 16'd64, 10'd100, 10'd50, 1'b0);
        pixel("base", 10'd110, 10'd52, 1'b1, 16'd394);

        // Just outside each edge
        pixel("right", 10'd164, 10'd60, 1'b0, 16'd0);
        pixel("left", 10'd99, 10'd60, 1'b0, 16'd0);
        pixel("below", 10'd120, 10'd114, 1'b0, 16'd0);
        pixel("above", 10'd120, 10'd49, 1'b0, 16'd0);

        // Address wrap modulo 2^16
        set_sprite(16'hFFF0, 16'd64, 16'd4, 10'd100, 10'd50, 1'b0);
        pixel("wrap", 10'd132, 10'd50, 1'b1, 16'h0010);
        pixel("wrap_row3", 10'd100, 10'd53, 1'b1, 16'h00B0);

        // Degenerate sizes
        set_sprite(16'd0, 16'd0, 16'd64, 10'd100, 10'd50, 1'b0);
        pixel("w0", 10'd100, 10'd50, 1'b0, 16'd0);
        set_sprite(16'd0, 16'd64, 16'd0, 10'd100, 10'd50, 1'b0);
        pixel("h0", 10'd100, 10'd50, 1'b0, 16'd0);

        // Sprite hanging off the right edge must not hit on the left side
        set_sprite(16'd0, 16'd64, 16'd64, 10'd1000, 10'd50, 1'b0);
        pixel("nowrap", 10'd5, 10'd50, 1'b0, 16'd0);
        pixel("edge1023", 10'd1023, 10'd51, 1'b1, 16'd87);

        // Mid-frame reset pulse
        set_sprite(16'd0, 16'd64, 16'd64, 10'd100, 10'd50, 1'b0);
        hcount = 10'd101;
        vcount = 10'd51;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.valid", {31'b0, valid}, 32'd0);
        check("midrst.addr", {16'b0, addr_output}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release.valid", {31'b0, valid}, 32'd1);
        check("release.addr", {16'b0, addr_output}, 32'd65);

        // Horizontal flip bit
        set_sprite(16'd0, 16'd64, 16'd64, 10'd100, 10'd50, 1'b1);
`ifdef ADDR_CAL_HFLIP_EN
        pixel("flip_tl", 10'd100, 10'd50, 1'b1, 16'd63);
        pixel("flip_r1", 10'd163, 10'd51, 1'b1, 16'd64);
        pixel("flip_out", 10'd164, 10'd51, 1'b0, 16'd0);
`else
        pixel("noflip_tl", 10'd100, 10'd50, 1'b1, 16'd0);
        pixel("noflip_r1", 10'd163, 10'd51, 1'b1, 16'd127);
`endif
        set_sprite(16'd0, 16'd64, 16'd64, 10'd100, 10'd50, 1'b0);
        pixel("flip0_tl", 10'd100, 10'd50, 1'b1, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
